// File: rtl/keypad_event_queue_if.sv
// Event delivery handshake between the keypad event queue and the front-panel logic.
interface keypad_event_queue_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_key;
   logic       evt_press;
   logic       evt_repeat;

   modport master (output evt_valid, evt_key, evt_press, evt_repeat, input evt_ready);
   modport slave  (input evt_valid, evt_key, evt_press, evt_repeat, output evt_ready);
endinterface

// File: rtl/keypad_event_queue.sv
// Converts debounced key levels into press/release/auto-repeat events buffered in a show-ahead FIFO.
// Edges are lossless (they stall); only repeats may be dropped, which raises the sticky overflow flag.
module keypad_event_queue #(
   parameter int FIFO_DEPTH   = 8,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 13500000,
   parameter int REPEAT_RATE  = 2700000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [15:0]                   button_state,
   keypad_event_queue_if.master          evt,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX + 1);

   typedef struct packed {
      logic [3:0] key;
      logic       press;
      logic       rep;
   } event_t;

   event_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [15:0]     bs_q, tracked, diff;
   logic [3:0]      edge_key;
   logic            rep_active;
   logic [3:0]      rep_key;
   logic [TW-1:0]   rep_timer;
   logic            pop, push_ok, edge_pend, edge_push;
   logic            rep_fire, rep_push, rep_drop, push;
   event_t          push_evt;

   assign diff = bs_q ^ tracked;

   always_comb begin
      edge_key = '0;
      for (int i = 15; i >= 0; i--) begin
         if (diff[i]) edge_key = 4'(i);
      end
   end

   assign pop       = evt.evt_valid && evt.evt_ready;
   assign push_ok   = (fifo_count < CW'(FIFO_DEPTH)) || pop;
   assign edge_pend = (diff != '0);
   assign edge_push = edge_pend && push_ok;
   // A pending edge always wins; an expired repeat simply waits with the timer parked at zero.
   assign rep_fire  = (REPEAT_EN != 0) && rep_active && (rep_timer == '0) && !edge_pend;
   assign rep_push  = rep_fire && push_ok;
   assign rep_drop  = rep_fire && !push_ok;
   assign push      = edge_push || rep_push;

   always_comb begin
      push_evt = '0;
      if (edge_pend) begin
         push_evt.key   = edge_key;
         push_evt.press = bs_q[edge_key];
         push_evt.rep   = 1'b0;
      end else begin
         push_evt.key   = rep_key;
         push_evt.press = 1'b1;
         push_evt.rep   = 1'b1;
      end
   end

   assign evt.evt_valid  = (fifo_count != '0);
   assign evt.evt_key    = mem[rd_ptr].key;
   assign evt.evt_press  = mem[rd_ptr].press;
   assign evt.evt_repeat = mem[rd_ptr].rep;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         bs_q       <= '0;
         tracked    <= '0;
         rep_active <= 1'b0;
         rep_key    <= '0;
         rep_timer  <= '0;
         overflow   <= 1'b0;
      end else begin
         bs_q <= button_state;
         if (edge_push) tracked[edge_key] <= bs_q[edge_key];

         if (push) begin
            mem[wr_ptr] <= push_evt;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         if (rep_drop)            overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;

         if (REPEAT_EN != 0) begin
            if (edge_push && bs_q[edge_key]) begin
               rep_active <= 1'b1;
               rep_key    <= edge_key;
               rep_timer  <= TW'(REPEAT_DELAY - 1);
            end else if (edge_push && (edge_key == rep_key)) begin
               rep_active <= 1'b0;
            end else if (rep_active) begin
               if (rep_timer != '0)  rep_timer <= rep_timer - 1'b1;
               else if (!edge_pend)  rep_timer <= TW'(REPEAT_RATE - 1);
            end
         end
      end
   end
endmodule
